// File: rtl/core_msg_axi_slave.sv
// Core-side AXI4 single-beat responder: core-reset control, slot descriptor stream to the core,
// and status reads that pop core completion messages.
module core_msg_axi_slave #(
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int DESC_DEPTH = 4,
    parameter int STAT_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  core_reset,
    output logic [3:0]            desc_slot,
    output logic [15:0]           desc_addr,
    output logic [15:0]           desc_len,
    output logic [15:0]           desc_flag,
    output logic                  desc_valid,
    input  logic                  desc_ready,
    input  logic [31:0]           stat_data,
    input  logic                  stat_valid,
    output logic                  stat_ready
);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic       R_IDLE = 1'b0;
    localparam logic       R_RESP = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(16'hFFF8);
    localparam logic [ADDR_WIDTH-1:0] STAT_ADDR = ADDR_WIDTH'(16'h8000);
    localparam logic [ADDR_WIDTH-1:0] DESC_LO   = ADDR_WIDTH'(16'h0100);
    localparam logic [ADDR_WIDTH-1:0] DESC_HI   = ADDR_WIDTH'(16'h0178);

    localparam int DPW = $clog2(DESC_DEPTH);
    localparam int SPW = $clog2(STAT_DEPTH);
    localparam logic [DPW:0] DESC_FULL = (DPW + 1)'(DESC_DEPTH);
    localparam logic [SPW:0] STAT_FULL = (SPW + 1)'(STAT_DEPTH);

    // Write channel state
    logic [1:0]            w_state_q;
    logic                  up_q;
    logic                  aw_held_q, w_held_q;
    logic [ID_WIDTH-1:0]   awid_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [7:0]            awlen_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  bvalid_q;
    logic [ID_WIDTH-1:0]   bid_q;
    logic [1:0]            bresp_q;
    logic                  core_reset_q;

    // Read channel state
    logic                  r_state_q;
    logic                  rvalid_q, rlast_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    // FIFOs
    logic [51:0]  desc_mem [DESC_DEPTH];
    logic [DPW:0] desc_wptr_q, desc_rptr_q, desc_cnt_q;
    logic [31:0]  stat_mem [STAT_DEPTH];
    logic [SPW:0] stat_wptr_q, stat_rptr_q, stat_cnt_q;

    logic                  aw_hs, w_hs, w_done, ar_hs;
    logic [ID_WIDTH-1:0]   eff_awid;
    logic [ADDR_WIDTH-1:0] eff_awaddr;
    logic [7:0]            eff_awlen;
    logic [DATA_WIDTH-1:0] eff_wdata;
    logic [STRB_WIDTH-1:0] eff_wstrb;
    logic [1:0]            wr_resp, rd_resp;
    logic                  wr_ctrl, wr_desc, wr_go, wr_commit;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_stat;
    logic                  desc_full, desc_empty, desc_push, desc_pop;
    logic                  stat_full, stat_empty, stat_push, stat_pop;
    logic [51:0]           desc_wdata;

    assign s_axi_awready = up_q && (w_state_q == W_IDLE) && !aw_held_q;
    assign s_axi_wready  = up_q && (w_state_q == W_IDLE) && !w_held_q;
    assign s_axi_arready = up_q && (r_state_q == R_IDLE);
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign core_reset    = core_reset_q;

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign w_done = w_hs && s_axi_wlast;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;

    // Bypass the incoming beat so a write can commit on the cycle its last half arrives
    assign eff_awid   = aw_held_q ? awid_q   : s_axi_awid;
    assign eff_awaddr = aw_held_q ? awaddr_q : s_axi_awaddr;
    assign eff_awlen  = aw_held_q ? awlen_q  : s_axi_awlen;
    assign eff_wdata  = w_held_q  ? wdata_q  : s_axi_wdata;
    assign eff_wstrb  = w_held_q  ? wstrb_q  : s_axi_wstrb;

    always_comb begin
        wr_resp = RESP_DECERR;
        wr_ctrl = 1'b0;
        wr_desc = 1'b0;
        if (eff_awlen != 8'd0) begin
            wr_resp = RESP_SLVERR;
        end else if (eff_awaddr == CTRL_ADDR) begin
            wr_resp = RESP_OKAY;
            wr_ctrl = eff_wstrb[7];
        end else if (eff_awaddr >= DESC_LO && eff_awaddr <= DESC_HI && eff_awaddr[2:0] == 3'd0) begin
            if (eff_wstrb == '1) begin
                wr_resp = RESP_OKAY;
                wr_desc = 1'b1;
            end else begin
                wr_resp = RESP_SLVERR;
            end
        end else if (eff_awaddr == STAT_ADDR) begin
            wr_resp = RESP_SLVERR;
        end
    end

    assign wr_go      = (w_state_q != W_RESP) && (aw_held_q || aw_hs) && (w_held_q || w_done);
    assign wr_commit  = wr_go && !(wr_desc && desc_full);
    assign desc_push  = wr_commit && wr_desc;
    assign desc_wdata = {eff_awaddr[6:3], eff_wdata[47:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_q         <= 1'b0;
            w_state_q    <= W_IDLE;
            aw_held_q    <= 1'b0;
            w_held_q     <= 1'b0;
            awid_q       <= '0;
            awaddr_q     <= '0;
            awlen_q      <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bvalid_q     <= 1'b0;
            bid_q        <= '0;
            bresp_q      <= RESP_OKAY;
            core_reset_q <= 1'b1;
        end else begin
            up_q <= 1'b1;
            case (w_state_q)
                W_IDLE, W_DATA: begin
                    if (aw_hs) begin
                        aw_held_q <= 1'b1;
                        awid_q    <= s_axi_awid;
                        awaddr_q  <= s_axi_awaddr;
                        awlen_q   <= s_axi_awlen;
                    end
                    if (w_done) begin
                        w_held_q <= 1'b1;
                        wdata_q  <= s_axi_wdata;
                        wstrb_q  <= s_axi_wstrb;
                    end
                    if (wr_commit) begin
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bid_q     <= eff_awid;
                        bresp_q   <= wr_resp;
                        w_state_q <= W_RESP;
                        if (wr_ctrl) core_reset_q <= eff_wdata[56];
                    end else if (wr_go) begin
                        w_state_q <= W_DATA;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_resp = RESP_DECERR;
        rd_data = '0;
        rd_stat = 1'b0;
        if (s_axi_arlen != 8'd0) begin
            rd_resp = RESP_SLVERR;
        end else if (s_axi_araddr == CTRL_ADDR) begin
            rd_resp = RESP_OKAY;
            rd_data = {7'd0, core_reset_q, 56'd0};
        end else if (s_axi_araddr == STAT_ADDR) begin
            rd_resp = RESP_OKAY;
            rd_stat = !stat_empty;
            if (!stat_empty) rd_data = {32'd0, stat_mem[stat_rptr_q[SPW-1:0]]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else if (r_state_q == R_IDLE) begin
            if (ar_hs) begin
                r_state_q <= R_RESP;
                rvalid_q  <= 1'b1;
                rlast_q   <= 1'b1;
                rid_q     <= s_axi_arid;
                rdata_q   <= rd_data;
                rresp_q   <= rd_resp;
            end
        end else if (s_axi_rready) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end
    end

    // Descriptor FIFO: head is presented directly on desc_*
    assign desc_full  = desc_cnt_q == DESC_FULL;
    assign desc_empty = desc_cnt_q == '0;
    assign desc_valid = !desc_empty;
    assign desc_pop   = desc_valid && desc_ready;
    assign {desc_slot, desc_addr, desc_len, desc_flag} = desc_mem[desc_rptr_q[DPW-1:0]];

    always_ff @(posedge clk) begin
        if (desc_push) desc_mem[desc_wptr_q[DPW-1:0]] <= desc_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            desc_wptr_q <= '0;
            desc_rptr_q <= '0;
            desc_cnt_q  <= '0;
        end else begin
            if (desc_push) desc_wptr_q <= desc_wptr_q + 1'b1;
            if (desc_pop) desc_rptr_q <= desc_rptr_q + 1'b1;
            if (desc_push && !desc_pop && !desc_full) desc_cnt_q <= desc_cnt_q + 1'b1;
            else if (!desc_push && desc_pop) desc_cnt_q <= desc_cnt_q - 1'b1;
        end
    end

    // Status FIFO: a pop frees the slot the same cycle, so a full FIFO may still accept a push
    assign stat_full  = stat_cnt_q == STAT_FULL;
    assign stat_empty = stat_cnt_q == '0;
    assign stat_pop   = ar_hs && rd_stat;
    assign stat_ready = !stat_full || stat_pop;
    assign stat_push  = stat_valid && stat_ready;

    always_ff @(posedge clk) begin
        if (stat_push) stat_mem[stat_wptr_q[SPW-1:0]] <= stat_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_wptr_q <= '0;
            stat_rptr_q <= '0;
            stat_cnt_q  <= '0;
        end else begin
            if (stat_push) stat_wptr_q <= stat_wptr_q + 1'b1;
            if (stat_pop) stat_rptr_q <= stat_rptr_q + 1'b1;
            if (stat_push && !stat_pop && !stat_full) stat_cnt_q <= stat_cnt_q + 1'b1;
            else if (!stat_push && stat_pop) stat_cnt_q <= stat_cnt_q - 1'b1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst,
                           eff_wdata[63:57], eff_wdata[55:48]};

endmodule
